// File: rtl/cam_chunk_packer_if.sv
// Byte-wide chunk stream from the packer to the RAM writer.
// Valid/ready handshake with start/last framing flags.
interface cam_chunk_packer_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_start;
    logic       out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_start,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_start,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/cam_chunk_packer.sv
// Buffers camera bytes and end-of-frame markers in a 9-bit FIFO and
// emits header/payload/trailer chunks sized for one Ethernet frame.
module cam_chunk_packer #(
    parameter int CHUNK_BYTES = 1396,
    parameter int FIFO_DEPTH  = 2048,
    parameter int FIFO_AW     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_valid,
    input  logic [7:0]         cam_data,
    input  logic               frame_done,
    cam_chunk_packer_if.master o_chunk,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_level
);
    localparam int CW = $clog2(CHUNK_BYTES + 1);
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(CHUNK_BYTES);
    localparam logic [FIFO_AW:0] ONE      = (FIFO_AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_H0,
        S_H1,
        S_H2,
        S_PAY,
        S_TRL
    } state_t;

    logic [8:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic [FIFO_AW:0]   r_mcnt;
    logic               r_mk_pend;
    logic               r_ovf;
    state_t             r_state;
    logic               r_valid;
    logic [7:0]         r_data;
    logic               r_start;
    logic               r_last;
    logic               r_eof;
    logic [CW-1:0]      r_cnt;
    logic [7:0]         r_fid;
    logic [7:0]         r_cidx;

    logic               w_full;
    logic               w_empty;
    logic               w_push_mk;
    logic               w_push_px;
    logic               w_push;
    logic [8:0]         w_wdata;
    logic [8:0]         w_head;
    logic [FIFO_AW:0]   w_data_cnt;
    logic               w_go;
    logic               w_hs;
    logic               w_pop;
    logic               w_pop_mk;
    state_t             w_nstate;
    logic               w_nvalid;
    logic [7:0]         w_ndata;
    logic               w_nstart;
    logic               w_nlast;
    logic               w_neof;
    logic [CW-1:0]      w_ncnt;
    logic [7:0]         w_nfid;
    logic [7:0]         w_ncidx;

    // A pending marker outranks a pixel; the pixel is then lost.
    assign w_full     = (r_level == LVL_FULL);
    assign w_empty    = (r_level == '0);
    assign w_push_mk  = r_mk_pend && !w_full;
    assign w_push_px  = pix_valid && !w_full && !w_push_mk;
    assign w_push     = w_push_mk || w_push_px;
    assign w_wdata    = w_push_mk ? 9'h100 : {1'b0, cam_data};
    assign w_head     = r_mem[r_rd_ptr];
    assign w_data_cnt = r_level - r_mcnt;
    assign w_go       = (32'(w_data_cnt) >= CHUNK_BYTES) || (r_mcnt != '0);
    assign w_hs       = r_valid && o_chunk.out_ready;

    always_comb begin
        w_nstate = r_state;
        w_nvalid = r_valid;
        w_ndata  = r_data;
        w_nstart = r_start;
        w_nlast  = r_last;
        w_neof   = r_eof;
        w_ncnt   = r_cnt;
        w_nfid   = r_fid;
        w_ncidx  = r_cidx;
        w_pop    = 1'b0;
        w_pop_mk = 1'b0;
        unique case (r_state)
            S_IDLE: if (w_go) begin
                w_nstate = S_H0;
                w_nvalid = 1'b1;
                w_ndata  = 8'hA5;
                w_nstart = 1'b1;
                w_nlast  = 1'b0;
                w_ncnt   = '0;
            end
            S_H0: if (w_hs) begin
                w_nstate = S_H1;
                w_ndata  = r_fid;
                w_nstart = 1'b0;
            end
            S_H1: if (w_hs) begin
                w_nstate = S_H2;
                w_ndata  = r_cidx;
            end
            // Next output byte is loaded from the FIFO head as the
            // current one is accepted, keeping one byte per cycle.
            S_H2, S_PAY: if (w_hs || !r_valid) begin
                if (r_cnt == CNT_MAX) begin
                    w_nstate = S_TRL;
                    w_nvalid = 1'b1;
                    w_ndata  = 8'h00;
                    w_neof   = 1'b0;
                    w_nlast  = 1'b1;
                end else if (w_empty) begin
                    w_nstate = S_PAY;
                    w_nvalid = 1'b0;
                end else if (w_head[8]) begin
                    w_pop    = 1'b1;
                    w_pop_mk = 1'b1;
                    w_nstate = S_TRL;
                    w_nvalid = 1'b1;
                    w_ndata  = 8'h01;
                    w_neof   = 1'b1;
                    w_nlast  = 1'b1;
                end else begin
                    w_pop    = 1'b1;
                    w_nstate = S_PAY;
                    w_nvalid = 1'b1;
                    w_ndata  = w_head[7:0];
                    w_ncnt   = r_cnt + 1'b1;
                end
            end
            S_TRL: if (w_hs) begin
                w_nstate = S_IDLE;
                w_nvalid = 1'b0;
                w_nlast  = 1'b0;
                if (r_eof) begin
                    w_nfid  = r_fid + 8'd1;
                    w_ncidx = 8'd0;
                end else begin
                    w_ncidx = r_cidx + 8'd1;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_mcnt    <= '0;
            r_mk_pend <= 1'b0;
            r_ovf     <= 1'b0;
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_data    <= 8'h00;
            r_start   <= 1'b0;
            r_last    <= 1'b0;
            r_eof     <= 1'b0;
            r_cnt     <= '0;
            r_fid     <= 8'h00;
            r_cidx    <= 8'h00;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level   <= r_level + (w_push ? ONE : '0) - (w_pop ? ONE : '0);
            r_mcnt    <= r_mcnt + (w_push_mk ? ONE : '0) - (w_pop_mk ? ONE : '0);
            r_mk_pend <= frame_done || (r_mk_pend && !w_push_mk);
            r_ovf     <= r_ovf || (pix_valid && !w_push_px);
            r_state   <= w_nstate;
            r_valid   <= w_nvalid;
            r_data    <= w_ndata;
            r_start   <= w_nstart;
            r_last    <= w_nlast;
            r_eof     <= w_neof;
            r_cnt     <= w_ncnt;
            r_fid     <= w_nfid;
            r_cidx    <= w_ncidx;
        end
    end

    assign o_chunk.out_data  = r_data;
    assign o_chunk.out_valid = r_valid;
    assign o_chunk.out_start = r_start;
    assign o_chunk.out_last  = r_last;
    assign overflow          = r_ovf;
    assign fifo_level        = r_level;
endmodule
